// File: rtl/dmem_arb_if.sv
// Signal bundle between the two requesters, the arbiter and the shared data memory.
// The slave view belongs to the arbiter; the master view drives requests and models the memory.
interface dmem_arb_if #(
  parameter int ADDR_W = 16
);
  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [31:0]       i_wdata0;
  logic [31:0]       i_wdata1;
  logic [3:0]        i_bmask0;
  logic [3:0]        i_bmask1;
  logic              i_lock0;
  logic              i_lock1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_rvalid0;
  logic              o_rvalid1;
  logic [31:0]       o_rdata0;
  logic [31:0]       o_rdata1;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
    input  i_wdata0, i_wdata1, i_bmask0, i_bmask1, i_lock0, i_lock1,
    input  i_mem_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
    output i_wdata0, i_wdata1, i_bmask0, i_bmask1, i_lock0, i_lock1,
    output i_mem_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
  );
endinterface

// File: rtl/dmem_arb.sv
// Round-robin arbiter (LSU = port 0, debug host = port 1) for one synchronous data-memory port,
// with bounded lock bursts and a tag pipeline that steers read data back to the issuing port.
module dmem_arb #(
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int HOLD_MAX = 8
) (
  input logic       i_clk,
  input logic       i_rst,
  dmem_arb_if.slave bus
);
  localparam int              CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(HOLD_MAX - 1);

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_any_gnt;
  logic               w_lock_sel;
  logic               w_keep;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [31:0]        w_mem_wdata;
  logic [3:0]         w_mem_bmask;
  logic               r_last_ptr;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_port;

  // r_last_ptr names the port that loses a tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (i_rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (bus.i_req0 && bus.i_req1) begin
      w_gnt0 = r_last_ptr;
      w_gnt1 = ~r_last_ptr;
    end else begin
      w_gnt0 = bus.i_req0;
      w_gnt1 = bus.i_req1;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  // Granted port's payload onto the memory bus; lock from the loser is ignored.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 32'h0000_0000;
    w_mem_bmask = 4'h0;
    w_lock_sel  = 1'b0;
    if (w_gnt0) begin
      w_mem_we    = bus.i_we0;
      w_mem_addr  = bus.i_addr0;
      w_mem_wdata = bus.i_wdata0;
      w_mem_bmask = bus.i_bmask0;
      w_lock_sel  = bus.i_lock0;
    end else if (w_gnt1) begin
      w_mem_we    = bus.i_we1;
      w_mem_addr  = bus.i_addr1;
      w_mem_wdata = bus.i_wdata1;
      w_mem_bmask = bus.i_bmask1;
      w_lock_sel  = bus.i_lock1;
    end else begin
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = 32'h0000_0000;
      w_mem_bmask = 4'h0;
      w_lock_sel  = 1'b0;
    end
  end

  assign w_keep = w_lock_sel && (r_lock_cnt < LOCK_LIM);

  // Priority pointer and lock counter; the last locked grant of a burst hands priority away.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_ptr <= 1'b1;
      r_lock_cnt <= '0;
    end else if (w_any_gnt) begin
      r_last_ptr <= w_keep ? w_gnt0 : w_gnt1;
      r_lock_cnt <= w_keep ? (r_lock_cnt + CNT_W'(1)) : '0;
    end else begin
      r_lock_cnt <= '0;
    end
  end

  // Read tags ride alongside the memory latency so data returns in issue order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld  <= '0;
      r_tag_port <= '0;
    end else begin
      r_tag_vld[0]  <= w_any_gnt & ~w_mem_we;
      r_tag_port[0] <= w_gnt1;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_tag_vld[k]  <= r_tag_vld[k-1];
        r_tag_port[k] <= r_tag_port[k-1];
      end
    end
  end

  assign bus.o_gnt0      = w_gnt0;
  assign bus.o_gnt1      = w_gnt1;
  assign bus.o_mem_req   = w_any_gnt;
  assign bus.o_mem_we    = w_mem_we;
  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_wdata = w_mem_wdata;
  assign bus.o_mem_bmask = w_mem_bmask;
  assign bus.o_rvalid0   = r_tag_vld[MEM_LAT-1] & ~r_tag_port[MEM_LAT-1];
  assign bus.o_rvalid1   = r_tag_vld[MEM_LAT-1] &  r_tag_port[MEM_LAT-1];
  assign bus.o_rdata0    = bus.i_mem_rdata;
  assign bus.o_rdata1    = bus.i_mem_rdata;
endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: two instances (MEM_LAT=1 and MEM_LAT=2) driven with identical
// requests, each behind its own behavioural memory read pipeline.
module tb_dmem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_arb_if #(.ADDR_W(16)) bus1 ();
  dmem_arb_if #(.ADDR_W(16)) bus2 ();

  dmem_arb #(.ADDR_W(16), .MEM_LAT(1), .HOLD_MAX(8)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  dmem_arb #(.ADDR_W(16), .MEM_LAT(2), .HOLD_MAX(8)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  // Behavioural memory: preset contents, byte-masked writes, 1- and 2-cycle read pipes.
  logic [31:0] mem [0:255];
  logic [31:0] rd1, rd2a, rd2b;
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h01] <= 32'h1111_1111;
      mem[8'h02] <= 32'h2222_2222;
      mem[8'h03] <= 32'h3333_3333;
      mem[8'h10] <= 32'hDEAD_BEEF;
      mem[8'h20] <= 32'h2020_2020;
    end else if (bus1.o_mem_req && bus1.o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus1.o_mem_bmask[b]) mem[bus1.o_mem_addr[7:0]][8*b +: 8] <= bus1.o_mem_wdata[8*b +: 8];
    end
    rd1  <= mem[bus1.o_mem_addr[7:0]];
    rd2a <= mem[bus2.o_mem_addr[7:0]];
    rd2b <= rd2a;
  end
  assign bus1.i_mem_rdata = rd1;
  assign bus2.i_mem_rdata = rd2b;

  typedef struct {
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  bmask0, bmask1;
  } in_t;

  typedef struct {
    in_t         in;
    logic        eg0, eg1, ewe;
    logic [15:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebmask;
    logic        erv0, erv1;
    logic [31:0] erdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    bus1.i_req0 = v.req0;     bus2.i_req0 = v.req0;
    bus1.i_req1 = v.req1;     bus2.i_req1 = v.req1;
    bus1.i_we0 = v.we0;       bus2.i_we0 = v.we0;
    bus1.i_we1 = v.we1;       bus2.i_we1 = v.we1;
    bus1.i_lock0 = v.lock0;   bus2.i_lock0 = v.lock0;
    bus1.i_lock1 = v.lock1;   bus2.i_lock1 = v.lock1;
    bus1.i_addr0 = v.addr0;   bus2.i_addr0 = v.addr0;
    bus1.i_addr1 = v.addr1;   bus2.i_addr1 = v.addr1;
    bus1.i_wdata0 = v.wdata0; bus2.i_wdata0 = v.wdata0;
    bus1.i_wdata1 = v.wdata1; bus2.i_wdata1 = v.wdata1;
    bus1.i_bmask0 = v.bmask0; bus2.i_bmask0 = v.bmask0;
    bus1.i_bmask1 = v.bmask1; bus2.i_bmask1 = v.bmask1;
  endtask

  function automatic in_t mkin(input logic r0, input logic r1, input logic w0, input logic w1,
                               input logic l0, input logic l1, input logic [15:0] a0,
                               input logic [15:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] m0, input logic [3:0] m1);
    in_t t;
    t.req0 = r0; t.req1 = r1; t.we0 = w0; t.we1 = w1; t.lock0 = l0; t.lock1 = l1;
    t.addr0 = a0; t.addr1 = a1; t.wdata0 = d0; t.wdata1 = d1; t.bmask0 = m0; t.bmask1 = m1;
    return t;
  endfunction

  function automatic vec_t mk(input in_t i, input logic g0, input logic g1, input logic we,
                              input logic [15:0] ea, input logic [31:0] ed, input logic [3:0] em,
                              input logic rv0, input logic rv1, input logic [31:0] erd);
    vec_t v;
    v.in = i; v.eg0 = g0; v.eg1 = g1; v.ewe = we; v.eaddr = ea; v.ewdata = ed; v.ebmask = em;
    v.erv0 = rv0; v.erv1 = rv1; v.erdata = erd;
    return v;
  endfunction

  vec_t vecs [10];
  in_t  both_rd, idle_in, rd0_in;

  initial begin
    both_rd = mkin(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002, 32'h0, 32'h0, 4'h0, 4'h0);
    idle_in = mkin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0);
    rd0_in  = mkin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0);
    // rvalid/rdata columns are for the MEM_LAT=1 instance and reflect the previous row's grant
    vecs[0] = mk(both_rd, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    vecs[1] = mk(both_rd, 1'b0, 1'b1, 1'b0, 16'h0002, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_1111);
    vecs[2] = mk(both_rd, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2222_2222);
    vecs[3] = mk(both_rd, 1'b0, 1'b1, 1'b0, 16'h0002, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_1111);
    vecs[4] = mk(mkin(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 32'h0, 32'h0, 4'h0, 4'h0),
                 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2222_2222);
    vecs[5] = mk(mkin(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 32'h1234_5678, 32'h0, 4'h3, 4'h0),
                 1'b1, 1'b0, 1'b1, 16'h0004, 32'h1234_5678, 4'h3, 1'b0, 1'b1, 32'hDEAD_BEEF);
    vecs[6] = mk(idle_in, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    vecs[7] = mk(mkin(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0020, 32'hAAAA_5555, 32'hCAFE_F00D, 4'hF, 4'hF),
                 1'b0, 1'b1, 1'b0, 16'h0020, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
    vecs[8] = mk(mkin(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 32'h0, 32'h0, 4'h0, 4'h0),
                 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2020_2020);
    vecs[9] = mk(both_rd, 1'b0, 1'b1, 1'b0, 16'h0002, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_1111);

    // Reset held with both ports requesting: everything quiet.
    apply(both_rd);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(bus1.o_gnt0), 32'h0);
    chk("rst_gnt1", 32'(bus1.o_gnt1), 32'h0);
    chk("rst_mem_req", 32'(bus1.o_mem_req), 32'h0);
    chk("rst_mem_we", 32'(bus1.o_mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus1.o_mem_addr), 32'h0);
    chk("rst_mem_wdata", bus1.o_mem_wdata, 32'h0);
    chk("rst_mem_bmask", 32'(bus1.o_mem_bmask), 32'h0);
    chk("rst_rvalid", 32'({bus1.o_rvalid0, bus1.o_rvalid1, bus2.o_rvalid0, bus2.o_rvalid1}), 32'h0);
    chk("rst_gnt_lat2", 32'({bus2.o_gnt0, bus2.o_gnt1}), 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0;
      apply(vecs[i].in);
      #1;
      chk($sformatf("v%0d_gnt0", i), 32'(bus1.o_gnt0), 32'(vecs[i].eg0));
      chk($sformatf("v%0d_gnt1", i), 32'(bus1.o_gnt1), 32'(vecs[i].eg1));
      chk($sformatf("v%0d_mem_req", i), 32'(bus1.o_mem_req), 32'(vecs[i].eg0 | vecs[i].eg1));
      chk($sformatf("v%0d_mem_we", i), 32'(bus1.o_mem_we), 32'(vecs[i].ewe));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus1.o_mem_addr), 32'(vecs[i].eaddr));
      chk($sformatf("v%0d_mem_wdata", i), bus1.o_mem_wdata, vecs[i].ewdata);
      chk($sformatf("v%0d_mem_bmask", i), 32'(bus1.o_mem_bmask), 32'(vecs[i].ebmask));
      chk($sformatf("v%0d_rvalid0", i), 32'(bus1.o_rvalid0), 32'(vecs[i].erv0));
      chk($sformatf("v%0d_rvalid1", i), 32'(bus1.o_rvalid1), 32'(vecs[i].erv1));
      if (vecs[i].erv0) chk($sformatf("v%0d_rdata0", i), bus1.o_rdata0, vecs[i].erdata);
      if (vecs[i].erv1) chk($sformatf("v%0d_rdata1", i), bus1.o_rdata1, vecs[i].erdata);
      chk($sformatf("v%0d_gnt_lat2", i), 32'({bus2.o_gnt0, bus2.o_gnt1}), 32'({vecs[i].eg0, vecs[i].eg1}));
    end

    // Lock burst: port 0 keeps priority for 8 contested grants, then must yield once.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(mkin(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002, 32'h0, 32'h0, 4'h0, 4'h0));
      #1;
      chk($sformatf("lock%0d_gnt0", i), 32'(bus1.o_gnt0), 32'(i < 8 || i == 9));
      chk($sformatf("lock%0d_gnt1", i), 32'(bus1.o_gnt1), 32'(i == 8));
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(idle_in);
    end

    // Mixed-port reads through the MEM_LAT=2 instance return in issue order.
    for (int c = 0; c < 6; c++) begin
      logic        e_rv0, e_rv1;
      logic [31:0] e_rd;
      @(negedge clk);
      case (c)
        0: apply(mkin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0));
        1: apply(mkin(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 32'h0, 32'h0, 4'h0, 4'h0));
        2: apply(mkin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 32'h0, 32'h0, 4'h0, 4'h0));
        default: apply(idle_in);
      endcase
      e_rv0 = (c == 2) || (c == 4);
      e_rv1 = (c == 3);
      e_rd  = (c == 2) ? 32'h1111_1111 : (c == 3) ? 32'h2222_2222 : 32'h3333_3333;
      #1;
      chk($sformatf("mix%0d_rvalid0", c), 32'(bus2.o_rvalid0), 32'(e_rv0));
      chk($sformatf("mix%0d_rvalid1", c), 32'(bus2.o_rvalid1), 32'(e_rv1));
      if (e_rv0) chk($sformatf("mix%0d_rdata0", c), bus2.o_rdata0, e_rd);
      if (e_rv1) chk($sformatf("mix%0d_rdata1", c), bus2.o_rdata1, e_rd);
    end

    // Reset one cycle after a granted port-0 read: tag dropped, tie goes to port 0 again.
    @(negedge clk);
    apply(rd0_in);
    #1;
    chk("rmid_gnt0", 32'(bus1.o_gnt0), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    apply(both_rd);
    #1;
    chk("rmid_rst_gnt", 32'({bus1.o_gnt0, bus1.o_gnt1}), 32'h0);
    chk("rmid_rst_rvalid", 32'({bus2.o_rvalid0, bus2.o_rvalid1}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid_rel_gnt0", 32'(bus1.o_gnt0), 32'h1);
    chk("rmid_rel_gnt1", 32'(bus1.o_gnt1), 32'h0);
    chk("rmid_rel_rvalid_lat2", 32'({bus2.o_rvalid0, bus2.o_rvalid1}), 32'h0);
    chk("rmid_rel_rvalid_lat1", 32'({bus1.o_rvalid0, bus1.o_rvalid1}), 32'h0);
    @(negedge clk);
    apply(idle_in);
    #1;
    chk("rmid_post_rvalid_lat2", 32'({bus2.o_rvalid0, bus2.o_rvalid1}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
